// File: rtl/ff_response_checker.sv
// Response checker for the flip-flop under test: compares q_obs against q_exp on strobed cycles,
// keeps vector/error counters and reports a pass verdict. Optional capture: FF_CHECKER_FIRST_ERR_EN.
module ff_response_checker #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             sample_valid,
   input  logic             q_obs,
   input  logic             q_exp,
   input  logic             vec_last,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             error_pulse,
   output logic [CNT_W-1:0] vector_count,
`ifdef FF_CHECKER_FIRST_ERR_EN
   output logic [CNT_W-1:0] error_count,
   output logic [CNT_W-1:0] first_err_idx,
   output logic             first_err_valid
`else
   output logic [CNT_W-1:0] error_count
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             error_pulse_q, error_pulse_d;
   logic [CNT_W-1:0] vector_count_q, vector_count_d;
   logic [CNT_W-1:0] error_count_q, error_count_d;
   logic             mismatch;
`ifdef FF_CHECKER_FIRST_ERR_EN
   logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
   logic             first_err_valid_q, first_err_valid_d;
`endif

   assign mismatch = q_obs ^ q_exp;

   always_comb begin
      state_d        = state_q;
      pass_d         = pass_q;
      error_pulse_d  = 1'b0;
      vector_count_d = vector_count_q;
      error_count_d  = error_count_q;
`ifdef FF_CHECKER_FIRST_ERR_EN
      first_err_idx_d   = first_err_idx_q;
      first_err_valid_d = first_err_valid_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d        = ST_RUN;
               pass_d         = 1'b0;
               vector_count_d = '0;
               error_count_d  = '0;
`ifdef FF_CHECKER_FIRST_ERR_EN
               first_err_idx_d   = '0;
               first_err_valid_d = 1'b0;
`endif
            end
         end
         ST_RUN: begin
            if (sample_valid) begin
               vector_count_d = vector_count_q + CNT_ONE;
               if (mismatch) begin
                  error_pulse_d = 1'b1;
                  // Error counter sticks at all-ones rather than wrapping back to a passing value.
                  if (error_count_q != CNT_MAX) begin
                     error_count_d = error_count_q + CNT_ONE;
                  end
`ifdef FF_CHECKER_FIRST_ERR_EN
                  if (!first_err_valid_q) begin
                     first_err_idx_d   = vector_count_q;
                     first_err_valid_d = 1'b1;
                  end
`endif
               end
               if (vec_last) begin
                  state_d = ST_DONE;
                  pass_d  = (error_count_q == '0) && !mismatch;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         pass_q         <= 1'b0;
         error_pulse_q  <= 1'b0;
         vector_count_q <= '0;
         error_count_q  <= '0;
`ifdef FF_CHECKER_FIRST_ERR_EN
         first_err_idx_q   <= '0;
         first_err_valid_q <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         pass_q         <= pass_d;
         error_pulse_q  <= error_pulse_d;
         vector_count_q <= vector_count_d;
         error_count_q  <= error_count_d;
`ifdef FF_CHECKER_FIRST_ERR_EN
         first_err_idx_q   <= first_err_idx_d;
         first_err_valid_q <= first_err_valid_d;
`endif
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign error_pulse  = error_pulse_q;
   assign vector_count = vector_count_q;
   assign error_count  = error_count_q;
`ifdef FF_CHECKER_FIRST_ERR_EN
   assign first_err_idx   = first_err_idx_q;
   assign first_err_valid = first_err_valid_q;
`endif

endmodule

// File: doc/ff_response_checker.md
# ff_response_checker

Synthesizable response checker that sits directly downstream of the flip-flop under test. It samples the observed `q` against an expected bit each strobed cycle, counts vectors and mismatches, and detects the final vector. It then reports a registered pass/fail verdict. It lets the flip-flop test run on hardware with the same vector/error accounting the simulation bench uses.

## Interface
- `CNT_W`, default 32: width of the vector and error counters; legal range 4..32.

- `clk`  in  1  rising-edge clock, shared with the flip-flop under test.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse; arms the checker and clears all counters.
- `sample_valid`  in  1  qualifies `q_obs`, `q_exp` and `vec_last` this cycle.
- `q_obs`  in  1  observed flip-flop output.
- `q_exp`  in  1  expected flip-flop output.
- `vec_last`  in  1  marks the current sample as the final vector.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid while `done`; 1 means zero mismatches.
- `error_pulse`  out  1  one-cycle pulse, registered, for each mismatching sample.
- `vector_count`  out  CNT_W  number of samples checked since `start`.
- `error_count`  out  CNT_W  number of mismatches since `start`.
- `first_err_idx`  out  CNT_W  index of the first mismatching sample. Present only with the macro.
- `first_err_valid`  out  1  `first_err_idx` holds a captured value. Present only with the macro.

## Operation
- **States:** IDLE, RUN, DONE. Two-bit state register.
- **IDLE:**
  - `start` moves the block to RUN and clears both counters, `pass` and `error_pulse`.
  - `sample_valid` is ignored.
- **RUN:**
  - On each cycle with `sample_valid`=1, `vector_count` increments by 1.
  - If `q_obs != q_exp`, `error_count` increments and `error_pulse` asserts on the next cycle.
  - If `vec_last`=1, the next state is DONE.
  - `pass` is loaded with 1 only if `error_count` was 0 and the last sample matched. The final vector counts toward both counters.
- **DONE:**
  - All outputs hold.
  - `start` restarts the run: counters are cleared and the state returns to RUN. Nothing else changes state.
- **`start` while in RUN:** ignored. There is no mid-run restart except by reset.
- **`vector_count` overflow:** wraps modulo 2^CNT_W.
- **`error_count` overflow:** saturates at all-ones and never wraps.
- **`vec_last` without `sample_valid`:** ignored.
- **Reset (`reset_n`=0 at a rising edge):**
  - Applies in any state, including mid-run; the run is discarded.
  - Next state is IDLE.
  - `busy`=0, `done`=0, `pass`=0, `error_pulse`=0, `vector_count`=0, `error_count`=0; `first_err_idx`=0 and `first_err_valid`=0 when the macro is compiled in.
  - Reset has priority over `start`.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- **Sample latency:** a sample presented at edge N is reflected in the counters and `error_pulse` after edge N. It is visible during cycle N+1.
- **Start latency:** `start` sampled at edge N gives `busy`=1 and cleared counters in cycle N+1.
- **Completion:** a `vec_last` sample at edge N gives `done`=1, `busy`=0 and a valid `pass` in cycle N+1.
- **Back-to-back samples:** `sample_valid` may be high every cycle; throughput is one vector per clock.
- **Input timing:** inputs must be stable around the rising edge. The upstream side drives them after its own edge, so `q_obs` is sampled at least one edge after the flip-flop updates.

## Configuration
- **Macro:** `FF_CHECKER_FIRST_ERR_EN`.
- **Defined:**
  - On the first mismatch of a run, the block captures the current pre-increment `vector_count` into `first_err_idx` and sets `first_err_valid`.
  - Later mismatches do not overwrite the capture.
  - `start` and reset clear both signals.
- **Undefined:** both ports and their registers are absent. All other behaviour is identical.

## Test plan
- **Reset mid-run.** Run 5 samples, then drive `reset_n`=0 for 1 cycle. Required: IDLE, both counters 0, `busy`=0, `done`=0.
- **Clean run.** `start`, then 8 matching samples with `vec_last` on the 8th. Required: `done`=1 one cycle later, `pass`=1, `vector_count`=8, `error_count`=0.
- **Mismatches including the last vector.** 10 samples with mismatches at indices 2 and 9, where 9 is the last. Required: `error_count`=2, `pass`=0, two single-cycle `error_pulse`s. With the macro: `first_err_idx`=2, `first_err_valid`=1.
- **Ignored inputs.** `start` and `sample_valid` pulses during RUN and DONE, and `vec_last` with `sample_valid`=0. Required: no restart in RUN, no counting in DONE, no early DONE.
- **Counter overflow.** With `CNT_W`=4, run 20 samples, all mismatching. Required: `vector_count`=4, which is 20 mod 16, and `error_count`=15, saturated.
- **Restart from DONE.** `start` asserted in DONE after a failing run. Required: RUN next cycle, counters 0; a subsequent clean 3-vector run ends with `pass`=1.
